mult_req_server: RTL and testbench

MULT_REQ_SERVER -- requirements
Module: mult_req_server

---
 rtl/mult_req_server_if.sv | 45 ++++
 rtl/mult_req_server.sv | 183 ++++++++++++++++++
 tb/tb_mult_req_server.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_req_server_if.sv
// Request/response handshake bundle for mult_req_server: two requester streams, two response streams.
interface mult_req_server_if #(
    parameter int unsigned DAT_BITS = 256,
    parameter int unsigned CTL_BITS = 8
);
    logic [2*DAT_BITS-1:0] i_req0_dat;
    logic [CTL_BITS-1:0]   i_req0_ctl;
    logic                  i_req0_val;
    logic                  o_req0_rdy;
    logic [2*DAT_BITS-1:0] i_req1_dat;
    logic [CTL_BITS-1:0]   i_req1_ctl;
    logic                  i_req1_val;
    logic                  o_req1_rdy;

    logic [2*DAT_BITS-1:0] o_rsp0_dat;
    logic [CTL_BITS-1:0]   o_rsp0_ctl;
    logic                  o_rsp0_val;
    logic                  i_rsp0_rdy;
    logic [2*DAT_BITS-1:0] o_rsp1_dat;
    logic [CTL_BITS-1:0]   o_rsp1_ctl;
    logic                  o_rsp1_val;
    logic                  i_rsp1_rdy;

    modport slave (
        input  i_req0_dat, i_req0_ctl, i_req0_val,
        output o_req0_rdy,
        input  i_req1_dat, i_req1_ctl, i_req1_val,
        output o_req1_rdy,
        output o_rsp0_dat, o_rsp0_ctl, o_rsp0_val,
        input  i_rsp0_rdy,
        output o_rsp1_dat, o_rsp1_ctl, o_rsp1_val,
        input  i_rsp1_rdy
    );

    modport master (
        output i_req0_dat, i_req0_ctl, i_req0_val,
        input  o_req0_rdy,
        output i_req1_dat, i_req1_ctl, i_req1_val,
        input  o_req1_rdy,
        input  o_rsp0_dat, o_rsp0_ctl, o_rsp0_val,
        output i_rsp0_rdy,
        input  o_rsp1_dat, o_rsp1_ctl, o_rsp1_val,
        output i_rsp1_rdy
    );
endinterface

// File: rtl/mult_req_server.sv
// Two-requester round-robin multiplier server: shift-and-add over DIGIT_BITS-wide digits of b,
// one full-width product per request, returned to the requester that issued it.
module mult_req_server #(
    parameter int unsigned DAT_BITS   = 256,
    parameter int unsigned CTL_BITS   = 8,
    parameter int unsigned DIGIT_BITS = 32
) (
    input  logic               i_clk,
    input  logic               i_rst,
    mult_req_server_if.slave   bus
);

    localparam int unsigned NDIG     = DAT_BITS / DIGIT_BITS;
    localparam int unsigned PRD_BITS = 2 * DAT_BITS;
    localparam int unsigned PP_BITS  = DAT_BITS + DIGIT_BITS;
    localparam int unsigned CNT_BITS = $clog2(NDIG + 1);

    if ((DAT_BITS % DIGIT_BITS) != 0) begin : g_bad_digit
        $error("DAT_BITS must be a multiple of DIGIT_BITS");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        HOLD = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [DAT_BITS-1:0]   a_q, a_d;
    logic [DAT_BITS-1:0]   b_q, b_d;
    logic [CTL_BITS-1:0]   ctl_q, ctl_d;
    logic                  src_q, src_d;
    logic                  last_q, last_d;
    logic [CNT_BITS-1:0]   cnt_q, cnt_d;
    logic [PRD_BITS-1:0]   acc_q, acc_d;

    logic                  rsp0_val_q, rsp0_val_d;
    logic [PRD_BITS-1:0]   rsp0_dat_q, rsp0_dat_d;
    logic [CTL_BITS-1:0]   rsp0_ctl_q, rsp0_ctl_d;
    logic                  rsp1_val_q, rsp1_val_d;
    logic [PRD_BITS-1:0]   rsp1_dat_q, rsp1_dat_d;
    logic [CTL_BITS-1:0]   rsp1_ctl_q, rsp1_ctl_d;

    logic                  gnt0_c, gnt1_c;
    logic                  rsp_hs_c;
    logic [DIGIT_BITS-1:0] digit_c;
    logic [PP_BITS-1:0]    pp_c;
    logic [PRD_BITS-1:0]   acc_step_c;

    // last_q = 1 means requester 1 was served last, so requester 0 wins a tie.
    always_comb begin
        gnt0_c = bus.i_req0_val && (!bus.i_req1_val || last_q);
        gnt1_c = bus.i_req1_val && (!bus.i_req0_val || !last_q);
    end

    assign bus.o_req0_rdy = i_rst && (state_q == IDLE) && gnt0_c;
    assign bus.o_req1_rdy = i_rst && (state_q == IDLE) && gnt1_c;

    // One digit of b per cycle, most significant first; top digit is consumed by shifting b left.
    always_comb begin
        digit_c    = b_q[DAT_BITS-1 -: DIGIT_BITS];
        pp_c       = PP_BITS'(a_q) * PP_BITS'(digit_c);
        acc_step_c = (acc_q << DIGIT_BITS) + PRD_BITS'(pp_c);
    end

    assign rsp_hs_c = src_q ? (rsp1_val_q && bus.i_rsp1_rdy)
                            : (rsp0_val_q && bus.i_rsp0_rdy);

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        ctl_d      = ctl_q;
        src_d      = src_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        rsp0_val_d = rsp0_val_q;
        rsp0_dat_d = rsp0_dat_q;
        rsp0_ctl_d = rsp0_ctl_q;
        rsp1_val_d = rsp1_val_q;
        rsp1_dat_d = rsp1_dat_q;
        rsp1_ctl_d = rsp1_ctl_q;

        case (state_q)
            IDLE: begin
                if (gnt0_c || gnt1_c) begin
                    src_d = gnt1_c;
                    if (gnt1_c) begin
                        a_d   = bus.i_req1_dat[DAT_BITS-1:0];
                        b_d   = bus.i_req1_dat[2*DAT_BITS-1:DAT_BITS];
                        ctl_d = bus.i_req1_ctl;
                    end else begin
                        a_d   = bus.i_req0_dat[DAT_BITS-1:0];
                        b_d   = bus.i_req0_dat[2*DAT_BITS-1:DAT_BITS];
                        ctl_d = bus.i_req0_ctl;
                    end
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = MUL;
                end
            end

            MUL: begin
                acc_d = acc_step_c;
                b_d   = b_q << DIGIT_BITS;
                cnt_d = cnt_q + CNT_BITS'(1);
                // Last digit: the response registers load the finished product directly.
                if (cnt_q == CNT_BITS'(NDIG - 1)) begin
                    state_d = HOLD;
                    if (src_q) begin
                        rsp1_val_d = 1'b1;
                        rsp1_dat_d = acc_step_c;
                        rsp1_ctl_d = ctl_q;
                    end else begin
                        rsp0_val_d = 1'b1;
                        rsp0_dat_d = acc_step_c;
                        rsp0_ctl_d = ctl_q;
                    end
                end
            end

            HOLD: begin
                if (rsp_hs_c) begin
                    state_d    = IDLE;
                    last_d     = src_q;
                    rsp0_val_d = 1'b0;
                    rsp0_dat_d = '0;
                    rsp0_ctl_d = '0;
                    rsp1_val_d = 1'b0;
                    rsp1_dat_d = '0;
                    rsp1_ctl_d = '0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            ctl_q      <= '0;
            src_q      <= 1'b0;
            last_q     <= 1'b1;
            cnt_q      <= '0;
            acc_q      <= '0;
            rsp0_val_q <= 1'b0;
            rsp0_dat_q <= '0;
            rsp0_ctl_q <= '0;
            rsp1_val_q <= 1'b0;
            rsp1_dat_q <= '0;
            rsp1_ctl_q <= '0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            ctl_q      <= ctl_d;
            src_q      <= src_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            rsp0_val_q <= rsp0_val_d;
            rsp0_dat_q <= rsp0_dat_d;
            rsp0_ctl_q <= rsp0_ctl_d;
            rsp1_val_q <= rsp1_val_d;
            rsp1_dat_q <= rsp1_dat_d;
            rsp1_ctl_q <= rsp1_ctl_d;
        end
    end

    assign bus.o_rsp0_val = rsp0_val_q;
    assign bus.o_rsp0_dat = rsp0_dat_q;
    assign bus.o_rsp0_ctl = rsp0_ctl_q;
    assign bus.o_rsp1_val = rsp1_val_q;
    assign bus.o_rsp1_dat = rsp1_dat_q;
    assign bus.o_rsp1_ctl = rsp1_ctl_q;

endmodule

// File: tb/tb_mult_req_server.sv
// Bench for mult_req_server: directed cases plus randomized traffic, checked every cycle
// against a transaction-level model of the server.
module tb_mult_req_server;

    localparam int unsigned DW   = 256;
    localparam int unsigned CW   = 8;
    localparam int unsigned PW   = 2 * DW;
    localparam int unsigned NDIG = 8;

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [CW-1:0] ctl;
    } txn_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [PW-1:0] req_dat [2];
    logic [CW-1:0] req_ctl [2];
    logic          req_val [2];
    logic          rsp_rdy [2];
    logic          d_rdy   [2];
    int            rdy_mode [2];

    mult_req_server_if #(.DAT_BITS(DW), .CTL_BITS(CW)) bus ();

    mult_req_server #(.DAT_BITS(DW), .CTL_BITS(CW), .DIGIT_BITS(32)) dut (
        .i_clk (clk),
        .i_rst (rst_n),
        .bus   (bus)
    );

    assign bus.i_req0_dat = req_dat[0];
    assign bus.i_req0_ctl = req_ctl[0];
    assign bus.i_req0_val = req_val[0];
    assign bus.i_req1_dat = req_dat[1];
    assign bus.i_req1_ctl = req_ctl[1];
    assign bus.i_req1_val = req_val[1];
    assign bus.i_rsp0_rdy = rsp_rdy[0];
    assign bus.i_rsp1_rdy = rsp_rdy[1];
    assign d_rdy[0]       = bus.o_req0_rdy;
    assign d_rdy[1]       = bus.o_req1_rdy;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    txn_t sq [2][$];

    // Model: at most one product in flight; it becomes visible NDIG+1 cycles after its accept.
    bit            m_busy = 1'b0;
    int            m_cnt = 0;
    int            m_src = 0;
    int            m_last = 1;
    logic [PW-1:0] m_prod = '0;
    logic [CW-1:0] m_ctl = '0;
    int            acc_log [$];
    int            acc_cyc = 0;

    int            rise_lat [2] = '{0, 0};
    logic [PW-1:0] seen_dat [2];
    logic [CW-1:0] seen_ctl [2];
    int            rsp_cnt  [2] = '{0, 0};
    int            vcyc     [2] = '{0, 0};
    bit            prev_val [2] = '{1'b0, 1'b0};

    task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd_op();
        logic [DW-1:0] v;
        int unsigned sel;
        sel = $urandom_range(0, 19);
        for (int i = 0; i < int'(DW / 32); i++) v[i*32 +: 32] = $urandom;
        if (sel == 0) v = '0;
        else if (sel == 1) v = '1;
        return v;
    endfunction

    // Compare every cycle, then advance the model to what the next rising edge must do.
    always @(negedge clk) begin : model
        logic          er [2];
        logic          ev [2];
        logic          dv [2];
        logic [PW-1:0] dd [2];
        logic [CW-1:0] dc [2];
        logic [PW-1:0] ta, tbv;
        cyc++;
        dv[0] = bus.o_rsp0_val; dv[1] = bus.o_rsp1_val;
        dd[0] = bus.o_rsp0_dat; dd[1] = bus.o_rsp1_dat;
        dc[0] = bus.o_rsp0_ctl; dc[1] = bus.o_rsp1_ctl;
        for (int n = 0; n < 2; n++) begin
            er[n] = rst_n && !m_busy && req_val[n] && (!req_val[1-n] || (m_last != n));
            ev[n] = m_busy && (m_src == n) && (m_cnt >= int'(NDIG));
            chk($sformatf("req%0d_rdy", n), PW'(d_rdy[n]), PW'(er[n]));
            chk($sformatf("rsp%0d_val", n), PW'(dv[n]), PW'(ev[n]));
            chk($sformatf("rsp%0d_dat", n), dd[n], ev[n] ? m_prod : PW'(0));
            chk($sformatf("rsp%0d_ctl", n), PW'(dc[n]), ev[n] ? PW'(m_ctl) : PW'(0));
            if (dv[n] && !prev_val[n]) rise_lat[n] = cyc - acc_cyc;
            if (dv[n]) begin
                vcyc[n]++;
                seen_dat[n] = dd[n];
                seen_ctl[n] = dc[n];
                if (rsp_rdy[n]) rsp_cnt[n]++;
            end
            prev_val[n] = dv[n];
        end
        if (!rst_n) begin
            m_busy = 1'b0;
            m_cnt  = 0;
            m_last = 1;
        end else if (m_busy) begin
            if (m_cnt >= int'(NDIG)) begin
                if (rsp_rdy[m_src]) begin
                    m_busy = 1'b0;
                    m_last = m_src;
                end
            end else begin
                m_cnt++;
            end
        end else begin
            for (int n = 0; n < 2; n++) begin
                if (er[n]) begin
                    ta     = PW'(req_dat[n][DW-1:0]);
                    tbv    = PW'(req_dat[n][PW-1:DW]);
                    m_prod = ta * tbv;
                    m_ctl  = req_ctl[n];
                    m_src  = n;
                    m_cnt  = 0;
                    m_busy = 1'b1;
                    acc_cyc = cyc;
                    acc_log.push_back(n);
                end
            end
        end
    end

    // Requester driver: present queue heads, pop after an observed transfer.
    initial begin : drv
        bit hs [2];
        for (int n = 0; n < 2; n++) begin
            req_val[n] = 1'b0;
            req_dat[n] = '0;
            req_ctl[n] = '0;
        end
        forever begin
            for (int n = 0; n < 2; n++) begin
                if (sq[n].size() != 0) begin
                    req_dat[n] = {sq[n][0].b, sq[n][0].a};
                    req_ctl[n] = sq[n][0].ctl;
                    req_val[n] = 1'b1;
                end else begin
                    req_val[n] = 1'b0;
                end
            end
            @(negedge clk);
            for (int n = 0; n < 2; n++) hs[n] = req_val[n] && d_rdy[n];
            @(posedge clk);
            #1;
            for (int n = 0; n < 2; n++) if (hs[n]) void'(sq[n].pop_front());
        end
    end

    // Response-ready driver: 0 = low, 1 = high, 2 = random (~70% high).
    initial begin : rdy_drv
        rsp_rdy[0] = 1'b1;
        rsp_rdy[1] = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            for (int n = 0; n < 2; n++) begin
                if (rdy_mode[n] == 2) rsp_rdy[n] = ($urandom_range(0, 9) < 7);
                else rsp_rdy[n] = (rdy_mode[n] == 1);
            end
        end
    end

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while ((sq[0].size() != 0 || sq[1].size() != 0 || m_busy) && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (k >= budget) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_idle timeout after %0d cycles", budget);
        end
    endtask

    task automatic push(input int n, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [CW-1:0] ctl);
        txn_t t;
        t.a = a;
        t.b = b;
        t.ctl = ctl;
        sq[n].push_back(t);
    endtask

    initial begin : main
        logic [PW-1:0] max_prod;
        int v0, c0, c1, k;
        rdy_mode[0] = 1;
        rdy_mode[1] = 1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Basic product and latency.
        push(0, DW'(3), DW'(5), 8'h11);
        wait_idle(100);
        chk("basic_lat", PW'(rise_lat[0]), PW'(9));
        chk("basic_dat", seen_dat[0], PW'(15));
        chk("basic_ctl", PW'(seen_ctl[0]), PW'(8'h11));
        chk("basic_rsp1_quiet", PW'(vcyc[1]), PW'(0));

        // Largest operands.
        push(1, '1, '1, 8'h22);
        wait_idle(100);
        max_prod = '0;
        max_prod = max_prod - (PW'(1) << 257) + PW'(1);
        chk("max_dat", seen_dat[1], max_prod);

        // Contention from reset.
        @(posedge clk);
        #1 rst_n = 1'b0;
        acc_log.delete();
        push(0, DW'(11), DW'(13), 8'hA0);
        push(0, DW'(17), DW'(19), 8'hA2);
        push(1, DW'(23), DW'(29), 8'hB1);
        push(1, DW'(31), DW'(37), 8'hB3);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        wait_idle(200);
        chk("cont_count", PW'(acc_log.size()), PW'(4));
        for (int i = 0; i < 4 && i < acc_log.size(); i++)
            chk($sformatf("cont_order%0d", i), PW'(acc_log[i]), PW'(i % 2));

        // Backpressure on port 0 while requester 1 waits.
        rdy_mode[0] = 0;
        @(posedge clk);
        #1;
        v0 = vcyc[0];
        push(0, rnd_op(), rnd_op(), 8'h5C);
        push(1, rnd_op(), rnd_op(), 8'h6D);
        k = 0;
        while (!(m_busy && m_src == 0 && m_cnt >= int'(NDIG)) && k < 50) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (k >= 50) begin
            vectors++;
            miscompares++;
            $display("FAIL bp_wait timeout");
        end
        repeat (20) @(posedge clk);
        #1 rdy_mode[0] = 1;
        wait_idle(200);
        chk("bp_val_cycles", PW'(vcyc[0] - v0), PW'(21));

        // Reset in the middle of a multiply.
        push(0, DW'(10), DW'(11), 8'h33);
        k = 0;
        while (!(m_busy && m_cnt == 4) && k < 50) begin
            @(posedge clk);
            #1;
            k++;
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        v0 = vcyc[0] + vcyc[1];
        repeat (30) @(posedge clk);
        #1;
        chk("rst_no_rsp", PW'(vcyc[0] + vcyc[1] - v0), PW'(0));
        push(0, DW'(7), DW'(9), 8'h44);
        wait_idle(100);
        chk("rst_next_dat", seen_dat[0], PW'(63));
        chk("rst_next_lat", PW'(rise_lat[0]), PW'(9));

        // Random traffic with random response stalls.
        c0 = rsp_cnt[0];
        c1 = rsp_cnt[1];
        rdy_mode[0] = 2;
        rdy_mode[1] = 2;
        for (int i = 0; i < 500; i++) begin
            push(0, rnd_op(), rnd_op(), CW'($urandom));
            push(1, rnd_op(), rnd_op(), CW'($urandom));
        end
        wait_idle(40000);
        rdy_mode[0] = 1;
        rdy_mode[1] = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("rand_cnt0", PW'(rsp_cnt[0] - c0), PW'(500));
        chk("rand_cnt1", PW'(rsp_cnt[1] - c1), PW'(500));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
